bcd_to_bin_seq: RTL and testbench

- Iterative reverse double-dabble converter from packed BCD to unsigned binary.
- Input is the 3-digit packed BCD sum plus decimal carry-out produced by the team's BCD adder datapath, a range of 0..1999.
- Produces the equivalent binary value for downstream binary arithmetic and display logic.
- Uses a start/busy/done handshake and converts one bit per clock.

---
 rtl/bcd_to_bin_seq.sv | 129 ++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// Iterative reverse double-dabble: packed BCD (plus decimal carry) to unsigned binary,
// one bit per clock, with a start/busy/done handshake.
module bcd_to_bin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  input  logic                thou_in,
  output logic                busy,
  output logic                done,
  output logic                invalid,
  output logic [BIN_W-1:0]    bin_out
);

  localparam int WW = 4 * (DIGITS + 1);
  localparam int CW = (BIN_W > 2) ? $clog2(BIN_W) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_FIN
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WW-1:0]     r_work;
  logic [BIN_W-1:0]  r_acc;
  logic [CW-1:0]     r_step;
  logic              r_bad;
  logic              r_invalid;
  logic [BIN_W-1:0]  r_bin;

  logic [WW-1:0]     w_shift_work;
  logic [WW-1:0]     w_adj_work;
  logic [BIN_W-1:0]  w_shift_acc;
  logic [DIGITS-1:0] w_nib_bad;
  logic              w_bad;

  assign w_shift_work = r_work >> 1;
  assign w_shift_acc  = {r_work[0], r_acc[BIN_W-1:1]};

  // After the shift, a BCD nibble worth >= 8 has absorbed a bit that should have
  // carried 5 into the lower digit; subtracting 3 restores the decimal weight.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS + 1; gi++) begin : g_adj
      assign w_adj_work[4*gi +: 4] = (w_shift_work[4*gi +: 4] >= 4'd8) ?
                                     (w_shift_work[4*gi +: 4] - 4'd3) :
                                      w_shift_work[4*gi +: 4];
    end
    for (gi = 0; gi < DIGITS; gi++) begin : g_chk
      assign w_nib_bad[gi] = (bcd_in[4*gi +: 4] > 4'd9);
    end
  endgenerate

  assign w_bad = |w_nib_bad;

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD: begin
        busy   = 1'b1;
        w_next = r_bad ? S_FIN : S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (r_step == LAST_STEP) w_next = S_FIN;
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_work    <= '0;
      r_acc     <= '0;
      r_step    <= '0;
      r_bad     <= 1'b0;
      r_invalid <= 1'b0;
      r_bin     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_work <= {3'b000, thou_in, bcd_in};
            r_acc  <= '0;
            r_step <= '0;
            r_bad  <= w_bad;
          end
        end
        S_LOAD: begin
          if (r_bad) begin
            r_bin     <= '0;
            r_invalid <= 1'b1;
          end
        end
        S_SHIFT: begin
          r_work <= w_adj_work;
          r_acc  <= w_shift_acc;
          r_step <= r_step + 1'b1;
          // Last shift lands directly in the output register on the edge into FIN.
          if (r_step == LAST_STEP) begin
            r_bin     <= w_shift_acc;
            r_invalid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign invalid = r_invalid;
  assign bin_out = r_bin;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: latency, busy length, carry/invalid inputs,
// back-to-back starts, start-while-busy and reset mid-conversion.
module tb_bcd_to_bin_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] bcd_in = 12'h000;
  logic        thou_in = 1'b0;
  logic        busy;
  logic        done;
  logic        invalid;
  logic [10:0] bin_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(.DIGITS(3), .BIN_W(11)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bcd_in (bcd_in),
    .thou_in(thou_in),
    .busy   (busy),
    .done   (done),
    .invalid(invalid),
    .bin_out(bin_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One conversion: pulse start, scramble inputs afterwards, count edges to done.
  task automatic run(input string tag, input logic th, input logic [11:0] b,
                     input logic [10:0] exp_bin, input logic exp_inv,
                     input int exp_edges, input int exp_busy);
    int n;
    int busy_n;
    thou_in = th;
    bcd_in  = b;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    bcd_in  = ~b;
    thou_in = ~th;
    n = 1;
    busy_n = busy ? 1 : 0;
    while (!done && n < 40) begin
      tick();
      n++;
      if (busy) busy_n++;
    end
    check({tag, " edges"}, n, exp_edges);
    check({tag, " busy_cycles"}, busy_n, exp_busy);
    check({tag, " bin_out"}, {21'd0, bin_out}, {21'd0, exp_bin});
    check({tag, " invalid"}, {31'd0, invalid}, {31'd0, exp_inv});
    $display("txn %s: thou=%0d bcd=%h -> bin_out=%0d invalid=%0d edges=%0d",
             tag, th, b, bin_out, invalid, n);
    tick();
    check({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int dones;
    int n;

    tick();
    tick();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset invalid", {31'd0, invalid}, 32'd0);
    check("reset bin_out", {21'd0, bin_out}, 32'd0);
    rst = 1'b0;
    tick();

    run("zero", 1'b0, 12'h000, 11'd0, 1'b0, 13, 12);
    run("mid579", 1'b0, 12'h579, 11'd579, 1'b0, 13, 12);
    run("b2b014", 1'b0, 12'h014, 11'd14, 1'b0, 13, 12);
    run("c1000", 1'b1, 12'h000, 11'd1000, 1'b0, 13, 12);
    run("c1998", 1'b1, 12'h998, 11'd1998, 1'b0, 13, 12);
    run("c1999", 1'b1, 12'h999, 11'd1999, 1'b0, 13, 12);
    run("bad0A5", 1'b0, 12'h0A5, 11'd0, 1'b1, 2, 1);
    run("ok005", 1'b0, 12'h005, 11'd5, 1'b0, 13, 12);

    // Start re-asserted at SHIFT step 5 must be ignored.
    bcd_in = 12'h123;
    thou_in = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    bcd_in = 12'h456;
    start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    n = 8;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("busystart edges", n, 13);
    check("busystart bin_out", {21'd0, bin_out}, 32'd123);
    for (int i = 0; i < 30; i++) begin
      if (done) dones++;
      tick();
    end
    check("busystart single_done", dones, 1);
    check("busystart held", {21'd0, bin_out}, 32'd123);
    $display("txn busystart: bcd=123 then 456 mid-shift -> bin_out=%0d dones=%0d", bin_out, dones);

    // Reset at SHIFT step 4 aborts the conversion.
    bcd_in = 12'h999;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst bin_out", {21'd0, bin_out}, 32'd0);
    check("midrst invalid", {31'd0, invalid}, 32'd0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) dones++;
      tick();
    end
    check("midrst no_done", dones, 0);
    $display("txn midrst: bcd=999 aborted -> busy=%0d bin_out=%0d dones=%0d", busy, bin_out, dones);

    run("after321", 1'b0, 12'h321, 11'd321, 1'b0, 13, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
